// File: rtl/demux_4_stream.sv
// Stream 1-to-4 demultiplexer: i_data is steered by i_sel into one of four
// 2-entry FIFOs, each with its own valid/ready sink port and pop counter.
module demux_4_stream #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     i_data,
    input  logic [1:0]       i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [W-1:0]     o_data0,
    output logic [W-1:0]     o_data1,
    output logic [W-1:0]     o_data2,
    output logic [W-1:0]     o_data3,
    output logic [3:0]       o_valid,
    input  logic [3:0]       i_ready,
    output logic [CNT_W-1:0] o_count0,
    output logic [CNT_W-1:0] o_count1,
    output logic [CNT_W-1:0] o_count2,
    output logic [CNT_W-1:0] o_count3
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             occ   [4];
    logic [W-1:0]     head  [4];
    logic [W-1:0]     tail  [4];
    logic [CNT_W-1:0] count [4];
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [3:0]       valid;

    // Readiness depends only on the addressed channel's registered occupancy.
    assign o_ready = rst_n && (occ[i_sel] != FULL);

    always_comb begin
        valid = '0;
        pop   = '0;
        push  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            valid[k] = (occ[k] != EMPTY);
            pop[k]   = valid[k] && i_ready[k];
            push[k]  = i_valid && o_ready && (i_sel == 2'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 4; k++) begin
                occ[k]   <= EMPTY;
                head[k]  <= '0;
                tail[k]  <= '0;
                count[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (pop[k])
                    count[k] <= count[k] + CNT_W'(1);
                unique case (occ[k])
                    EMPTY: begin
                        if (push[k]) begin
                            head[k] <= i_data;
                            occ[k]  <= ONE;
                        end
                    end
                    ONE: begin
                        // Push with pop: the old head leaves, the new entry takes its place.
                        if (push[k] && pop[k]) begin
                            head[k] <= i_data;
                        end else if (push[k]) begin
                            tail[k] <= i_data;
                            occ[k]  <= FULL;
                        end else if (pop[k]) begin
                            occ[k]  <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop[k]) begin
                            head[k] <= tail[k];
                            occ[k]  <= ONE;
                        end
                    end
                    default: occ[k] <= EMPTY;
                endcase
            end
        end
    end

    assign o_valid  = valid;
    assign o_data0  = valid[0] ? head[0] : '0;
    assign o_data1  = valid[1] ? head[1] : '0;
    assign o_data2  = valid[2] ? head[2] : '0;
    assign o_data3  = valid[3] ? head[3] : '0;
    assign o_count0 = count[0];
    assign o_count1 = count[1];
    assign o_count2 = count[2];
    assign o_count3 = count[3];

endmodule

// File: tb/tb_demux_4_stream.sv
// Directed bench for demux_4_stream: reset, routing, backpressure,
// push-with-pop, mid-run reset and counter wrap, with hand-computed expectations.
module tb_demux_4_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i_data;
    logic [1:0] i_sel;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] o_data0, o_data1, o_data2, o_data3;
    logic [3:0] o_valid;
    logic [3:0] i_ready;
    logic [7:0] o_count0, o_count1, o_count2, o_count3;

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;

    demux_4_stream #(.W(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (i_data),
        .i_sel    (i_sel),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_data0  (o_data0),
        .o_data1  (o_data1),
        .o_data2  (o_data2),
        .o_data3  (o_data3),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_count0 (o_count0),
        .o_count1 (o_count1),
        .o_count2 (o_count2),
        .o_count3 (o_count3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_passed++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        step();
        rst_n   = 1'b1;
    endtask

    initial begin
        // T1: garbage inputs with reset held for two edges
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_data  = 4'hA;
        i_sel   = 2'd2;
        i_ready = 4'b1111;
        step();
        step();
        check("t1_valid",  o_valid, 4'b0000);
        check("t1_data0",  o_data0, 4'h0);
        check("t1_data1",  o_data1, 4'h0);
        check("t1_data2",  o_data2, 4'h0);
        check("t1_data3",  o_data3, 4'h0);
        check("t1_cnt0",   o_count0, 8'd0);
        check("t1_cnt3",   o_count3, 8'd0);
        check("t1_ready",  o_ready, 1'b0);

        // T2: one value per channel; previous channel drains on the next edge
        rst_n   = 1'b1;
        i_valid = 1'b0;
        step();
        i_valid = 1'b1;
        i_sel = 2'd0; i_data = 4'h0; step();
        check("t2_valid0", o_valid, 4'b0001);
        check("t2_data0",  o_data0, 4'h0);
        i_sel = 2'd1; i_data = 4'h5; step();
        check("t2_valid1", o_valid, 4'b0010);
        check("t2_data1",  o_data1, 4'h5);
        i_sel = 2'd2; i_data = 4'hA; step();
        check("t2_valid2", o_valid, 4'b0100);
        check("t2_data2",  o_data2, 4'hA);
        i_sel = 2'd3; i_data = 4'hF; step();
        check("t2_valid3", o_valid, 4'b1000);
        check("t2_data3",  o_data3, 4'hF);
        i_valid = 1'b0;
        step();
        check("t2_vdone",  o_valid, 4'b0000);
        check("t2_cnt0",   o_count0, 8'd1);
        check("t2_cnt1",   o_count1, 8'd1);
        check("t2_cnt2",   o_count2, 8'd1);
        check("t2_cnt3",   o_count3, 8'd1);

        // T3: backpressure on channel 2
        do_reset();
        i_ready = 4'b1011;
        i_valid = 1'b1;
        i_sel   = 2'd2;
        i_data  = 4'h3; step();
        check("t3_ready_one", o_ready, 1'b1);
        i_data  = 4'h7; step();
        check("t3_ready_full", o_ready, 1'b0);
        check("t3_head3",  o_data2, 4'h3);
        i_valid = 1'b0;
        i_sel   = 2'd0;
        #1;
        check("t3_ready_sel0", o_ready, 1'b1);
        i_ready = 4'b1111;
        step();
        check("t3_head7",  o_data2, 4'h7);
        check("t3_cnt_a",  o_count2, 8'd1);
        step();
        check("t3_cnt_b",  o_count2, 8'd2);
        check("t3_empty",  o_valid[2], 1'b0);
        check("t3_data0",  o_data2, 4'h0);

        // T4: push and pop on the same edge while holding one entry
        i_ready = 4'b0000;
        i_valid = 1'b1;
        i_sel   = 2'd1;
        i_data  = 4'h1; step();
        check("t4_head1",  o_data1, 4'h1);
        i_ready = 4'b0010;
        i_data  = 4'h9; step();
        check("t4_valid",  o_valid[1], 1'b1);
        check("t4_head9",  o_data1, 4'h9);
        check("t4_cnt",    o_count1, 8'd1);
        check("t4_ready",  o_ready, 1'b1);
        i_valid = 1'b0;
        step();
        check("t4_drain",  o_valid[1], 1'b0);
        check("t4_cnt2",   o_count1, 8'd2);

        // T5: reset with channels 0 and 3 full
        i_ready = 4'b0000;
        i_valid = 1'b1;
        i_sel = 2'd0; i_data = 4'hC; step();
        i_sel = 2'd0; i_data = 4'hD; step();
        i_sel = 2'd3; i_data = 4'hE; step();
        i_sel = 2'd3; i_data = 4'h6; step();
        i_valid = 1'b0;
        i_sel   = 2'd0;
        #1;
        check("t5_full",   o_valid, 4'b1001);
        check("t5_ready",  o_ready, 1'b0);
        do_reset();
        #1;
        check("t5_valid",  o_valid, 4'b0000);
        check("t5_data0",  o_data0, 4'h0);
        check("t5_data3",  o_data3, 4'h0);
        check("t5_cnt1",   o_count1, 8'd0);
        check("t5_cnt2",   o_count2, 8'd0);
        check("t5_ready2", o_ready, 1'b1);
        i_ready = 4'b1111;
        step();
        check("t5_noold",  o_valid, 4'b0000);
        check("t5_cnt0",   o_count0, 8'd0);
        check("t5_cnt3",   o_count3, 8'd0);

        // T6: 256 pops on channel 0 wrap the counter; channel 1 keeps its count
        i_valid = 1'b1;
        i_sel   = 2'd1;
        i_data  = 4'h2; step();
        i_valid = 1'b0;
        step();
        check("t6_cnt1_pre", o_count1, 8'd1);
        i_valid = 1'b1;
        i_sel   = 2'd0;
        for (int i = 0; i < 256; i++) begin
            i_data = 4'(i);
            step();
        end
        check("t6_cnt0_ff", o_count0, 8'hFF);
        check("t6_head",    o_data0, 4'hF);
        i_valid = 1'b0;
        step();
        check("t6_cnt0_wrap", o_count0, 8'h00);
        check("t6_cnt1",      o_count1, 8'd1);
        check("t6_cnt2",      o_count2, 8'd0);
        check("t6_cnt3",      o_count3, 8'd0);
        check("t6_valid",     o_valid, 4'b0000);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
